// File: rtl/miner_host_pkg.sv
// Shared constants and types for the mining-controller host interface.
package miner_host_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 6;

    // Host word address map
    localparam logic [ADDR_W-1:0] ADDR_TGT_BASE = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_MSG_BASE = 6'h08;
    localparam logic [ADDR_W-1:0] ADDR_CMD      = 6'h20;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 6'h21;
    localparam logic [ADDR_W-1:0] ADDR_NONCE    = 6'h22;

    // STATUS register bit positions
    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FOUND   = 1;
    localparam int unsigned ST_ERROR   = 2;
    localparam int unsigned ST_CMD_ERR = 3;
    localparam int unsigned ST_WR_ERR  = 4;

    typedef enum logic [1:0] {
        H_IDLE    = 2'd0,
        H_TGT_REQ = 2'd1,
        H_MSG_REQ = 2'd2,
        H_MINING  = 2'd3
    } host_state_t;

endpackage

// File: rtl/host_regfile.sv
// Word-addressed target/header shadow storage with a write-protect input.
module host_regfile
    import miner_host_pkg::*;
#(
    parameter int unsigned TGT_WORDS = 8,
    parameter int unsigned MSG_WORDS = 19
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WORD_W-1:0]             wr_data,
    input  logic                          protect,
    output logic [WORD_W*TGT_WORDS-1:0]   target,
    output logic [WORD_W*MSG_WORDS-1:0]   msg
);

    // Shadow words update on an unprotected write that hits their address
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            target <= '0;
            msg    <= '0;
        end else if (wr_en && !protect) begin
            for (int i = 0; i < int'(TGT_WORDS); i++) begin
                if (wr_addr == ADDR_W'(32'(ADDR_TGT_BASE) + 32'(i)))
                    target[i*WORD_W +: WORD_W] <= wr_data;
            end
            for (int i = 0; i < int'(MSG_WORDS); i++) begin
                if (wr_addr == ADDR_W'(32'(ADDR_MSG_BASE) + 32'(i)))
                    msg[i*WORD_W +: WORD_W] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/miner_host_if.sv
// Host register slave driving newTarget/newMsg requests to the mining controller.
module miner_host_if
    import miner_host_pkg::*;
#(
    parameter int unsigned TGT_WORDS = 8,
    parameter int unsigned MSG_WORDS = 19
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WORD_W-1:0]             wr_data,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [WORD_W-1:0]             rd_data,
    output logic                          irq,
    output logic                          newTarget,
    output logic                          newMsg,
    output logic [WORD_W*TGT_WORDS-1:0]   target,
    output logic [WORD_W*MSG_WORDS-1:0]   msg,
    input  logic                          loadTarget,
    input  logic                          loadMsg,
    input  logic                          hash_found,
    input  logic                          error,
    input  logic [WORD_W-1:0]             nonce
);

    // Target window starts at address 0, so only its upper bound is decoded
    localparam logic [ADDR_W-1:0] TGT_END = ADDR_W'(32'(ADDR_TGT_BASE) + TGT_WORDS);
    localparam logic [ADDR_W-1:0] MSG_END = ADDR_W'(32'(ADDR_MSG_BASE) + MSG_WORDS);

    host_state_t       state, state_next;
    logic              msg_pend, found, cmd_err, wr_err, error_q;
    logic [WORD_W-1:0] nonce_q;
    logic              cmd_wr_c, status_wr_c, word_wr_c, protect_c, err_rise_c, mine_done_c;
    logic              busy_c, new_target_d, new_msg_d;
    logic [WORD_W-1:0] status_c, rd_word_c;

    assign cmd_wr_c    = wr_en && (wr_addr == ADDR_CMD);
    assign status_wr_c = wr_en && (wr_addr == ADDR_STATUS);
    assign word_wr_c   = wr_en && ((wr_addr < TGT_END) ||
                                   ((wr_addr >= ADDR_MSG_BASE) && (wr_addr < MSG_END)));
    assign protect_c   = (state == H_TGT_REQ) || (state == H_MSG_REQ);
    assign err_rise_c  = error && !error_q;
    assign mine_done_c = (state == H_MINING) && (hash_found || err_rise_c);

    host_regfile #(
        .TGT_WORDS (TGT_WORDS),
        .MSG_WORDS (MSG_WORDS)
    ) u_regfile (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .protect (protect_c),
        .target  (target),
        .msg     (msg)
    );

    // State register; request outputs registered from the next state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= H_IDLE;
            newTarget <= 1'b0;
            newMsg    <= 1'b0;
        end else begin
            state     <= state_next;
            newTarget <= new_target_d;
            newMsg    <= new_msg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            H_IDLE: begin
                if (cmd_wr_c && wr_data[0])      state_next = H_TGT_REQ;
                else if (cmd_wr_c && wr_data[1]) state_next = H_MSG_REQ;
            end
            H_TGT_REQ: if (loadTarget) state_next = msg_pend ? H_MSG_REQ : H_IDLE;
            H_MSG_REQ: if (loadMsg)    state_next = H_MINING;
            H_MINING:  if (mine_done_c) state_next = H_IDLE;
            default:   state_next = H_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        new_target_d = 1'b0;
        new_msg_d    = 1'b0;
        busy_c       = 1'b0;
        if (state_next == H_TGT_REQ) new_target_d = 1'b1;
        if (state_next == H_MSG_REQ) new_msg_d    = 1'b1;
        if (state == H_MINING)       busy_c       = 1'b1;
    end

    // Remember a combined commit so msg follows the target handshake
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            msg_pend <= 1'b0;
        else if ((state == H_IDLE) && cmd_wr_c && wr_data[0])
            msg_pend <= wr_data[1];
        else if ((state == H_TGT_REQ) && loadTarget)
            msg_pend <= 1'b0;
    end

    // Sticky status flags and irq; a new event wins over a STATUS clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            found   <= 1'b0;
            irq     <= 1'b0;
            cmd_err <= 1'b0;
            wr_err  <= 1'b0;
            error_q <= 1'b0;
            nonce_q <= '0;
        end else begin
            error_q <= error;
            if ((state == H_MINING) && hash_found) begin
                found   <= 1'b1;
                nonce_q <= nonce;
            end else if (((state == H_MSG_REQ) && loadMsg) || status_wr_c) begin
                found <= 1'b0;
            end
            if (mine_done_c)      irq <= 1'b1;
            else if (status_wr_c) irq <= 1'b0;
            if (cmd_wr_c && (state != H_IDLE)) cmd_err <= 1'b1;
            else if (status_wr_c)              cmd_err <= 1'b0;
            if (word_wr_c && protect_c) wr_err <= 1'b1;
            else if (status_wr_c)       wr_err <= 1'b0;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_c             = '0;
        status_c[ST_BUSY]    = busy_c;
        status_c[ST_FOUND]   = found;
        status_c[ST_ERROR]   = error;
        status_c[ST_CMD_ERR] = cmd_err;
        status_c[ST_WR_ERR]  = wr_err;
    end

    // Read mux; unmapped and write-only addresses read as zero
    always_comb begin
        rd_word_c = '0;
        for (int i = 0; i < int'(TGT_WORDS); i++) begin
            if (rd_addr == ADDR_W'(32'(ADDR_TGT_BASE) + 32'(i)))
                rd_word_c = target[i*WORD_W +: WORD_W];
        end
        for (int i = 0; i < int'(MSG_WORDS); i++) begin
            if (rd_addr == ADDR_W'(32'(ADDR_MSG_BASE) + 32'(i)))
                rd_word_c = msg[i*WORD_W +: WORD_W];
        end
        if (rd_addr == ADDR_STATUS) rd_word_c = status_c;
        if (rd_addr == ADDR_NONCE)  rd_word_c = nonce_q;
    end

    // Read data register, held between read strobes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)     rd_data <= '0;
        else if (rd_en) rd_data <= rd_word_c;
    end

endmodule

// File: tb/tb_miner_host_if.sv
// Self-checking bench for miner_host_if against a word-level reference model.
module tb_miner_host_if;

    localparam int TW = 8;
    localparam int MW = 19;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            wr_en = 1'b0;
    logic [5:0]      wr_addr = '0;
    logic [31:0]     wr_data = '0;
    logic            rd_en = 1'b0;
    logic [5:0]      rd_addr = '0;
    logic [31:0]     rd_data;
    logic            irq, newTarget, newMsg;
    logic [32*TW-1:0] target;
    logic [32*MW-1:0] msg;
    logic            loadTarget = 1'b0;
    logic            loadMsg = 1'b0;
    logic            hash_found = 1'b0;
    logic            error = 1'b0;
    logic [31:0]     nonce = '0;

    miner_host_if dut (
        .clk (clk), .n_rst (n_rst),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
        .irq (irq), .newTarget (newTarget), .newMsg (newMsg),
        .target (target), .msg (msg),
        .loadTarget (loadTarget), .loadMsg (loadMsg),
        .hash_found (hash_found), .error (error), .nonce (nonce)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic overlap = 1'b0;

    // Reference model: shadow words and host-visible flags
    logic [31:0] tgt_m [TW];
    logic [31:0] msg_m [MW];
    logic [31:0] nonce_m;
    logic found_m, busy_m, cmd_err_m, wr_err_m, irq_m;

    task automatic step();
        @(posedge clk);
        #1;
        if (newTarget && newMsg) overlap = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < TW; i++) tgt_m[i] = '0;
        for (int i = 0; i < MW; i++) msg_m[i] = '0;
        nonce_m = '0; found_m = 0; busy_m = 0; cmd_err_m = 0; wr_err_m = 0; irq_m = 0;
    endtask

    function automatic logic [31:0] exp_status();
        return {27'd0, wr_err_m, cmd_err_m, error, found_m, busy_m};
    endfunction

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    // Word write; a locked write is dropped and flags wr_err
    task automatic wr_word(input int a, input logic [31:0] d, input bit locked);
        bus_write(6'(a), d);
        if (locked)                wr_err_m = 1'b1;
        else if (a < TW)           tgt_m[a] = d;
        else if (a >= 8 && a < 8 + MW) msg_m[a-8] = d;
    endtask

    task automatic check_shadow(input string tag);
        for (int i = 0; i < TW; i++)
            chk($sformatf("%s_tgt%0d", tag, i), target[i*32 +: 32], tgt_m[i]);
        for (int i = 0; i < MW; i++)
            chk($sformatf("%s_msg%0d", tag, i), msg[i*32 +: 32], msg_m[i]);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(6'h21, d);
        chk(tag, d, exp_status());
    endtask

    task automatic ack_target(input int delay);
        repeat (delay) step();
        loadTarget = 1'b1; step(); loadTarget = 1'b0;
    endtask

    task automatic ack_msg(input int delay);
        repeat (delay) step();
        loadMsg = 1'b1; step(); loadMsg = 1'b0;
    endtask

    initial begin
        logic [31:0] d, old_w, new_w;
        int hi;

        // Reset values
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_irq", irq, 0);
        chk("rst_req", {newMsg, newTarget}, 0);
        check_shadow("rst");
        n_rst = 1'b1;
        step();
        check_status("rst_status");

        // Load shadow, target-only commit with a 3-cycle ack delay
        for (int i = 0; i < TW; i++) wr_word(i, 32'h1000_0000 + 32'(i), 0);
        for (int i = 0; i < MW; i++) wr_word(8 + i, $urandom, 0);
        check_shadow("load");
        bus_write(6'h20, 32'h1);
        hi = int'(newTarget);
        repeat (3) begin step(); hi += int'(newTarget); end
        loadTarget = 1'b1; step(); loadTarget = 1'b0;
        hi += int'(newTarget);
        chk("tgt_req_len", hi, 4);
        chk("tgt_only_no_msg", newMsg, 0);
        chk("tgt_word0", target[31:0], 32'h1000_0000);
        check_status("tgt_done_status");

        // Combined commit: target first, then msg, never both
        overlap = 1'b0;
        bus_write(6'h20, 32'h3);
        chk("both_tgt_first", {newMsg, newTarget}, 2'b01);
        ack_target($urandom_range(0, 3));
        chk("both_msg_next", {newMsg, newTarget}, 2'b10);
        ack_msg($urandom_range(0, 3));
        busy_m = 1; found_m = 0;
        chk("both_msg_drop", newMsg, 0);
        chk("both_overlap", overlap, 0);
        check_status("mining_status");

        // Hash found
        nonce = 32'hDEAD_BEEF; hash_found = 1'b1;
        step();
        hash_found = 1'b0; nonce = $urandom;
        busy_m = 0; found_m = 1; irq_m = 1; nonce_m = 32'hDEAD_BEEF;
        chk("found_irq", irq, irq_m);
        check_status("found_status");
        bus_read(6'h22, d);
        chk("found_nonce", d, nonce_m);
        bus_write(6'h21, 32'h0);
        found_m = 0; irq_m = 0;
        chk("clr_irq", irq, 0);
        check_status("clr_status");

        // Msg-only commit, then controller error
        for (int i = 0; i < 4; i++) wr_word(8 + $urandom_range(0, MW - 1), $urandom, 0);
        bus_write(6'h20, 32'h2);
        chk("msg_only_req", {newMsg, newTarget}, 2'b10);
        ack_msg($urandom_range(0, 3));
        busy_m = 1;
        error = 1'b1;
        step();
        busy_m = 0; irq_m = 1;
        chk("err_irq", irq, 1);
        check_status("err_status");
        bus_write(6'h21, 32'h0);
        irq_m = 0;
        chk("err_clr_irq", irq, 0);
        check_status("err_held_status");
        error = 1'b0;
        step();

        // Protected writes and rejected commands
        bus_write(6'h20, 32'h2);
        wr_word(8, $urandom, 1);
        check_shadow("locked");
        bus_write(6'h20, 32'h1);
        cmd_err_m = 1;
        chk("req_cmd_ignored", newTarget, 0);
        ack_msg($urandom_range(0, 2));
        busy_m = 1;
        bus_write(6'h20, 32'h1);
        chk("mine_cmd_ignored", {newMsg, newTarget}, 0);
        step();
        chk("mine_cmd_still", {newMsg, newTarget}, 0);
        check_status("errflags_status");
        wr_word(8 + $urandom_range(0, MW - 1), $urandom, 0);
        check_shadow("mine_write");

        // hash_found coincident with a CMD write
        nonce = $urandom;
        wr_en = 1'b1; wr_addr = 6'h20; wr_data = 32'h1; hash_found = 1'b1;
        step();
        wr_en = 1'b0; hash_found = 1'b0;
        nonce_m = nonce; found_m = 1; irq_m = 1; busy_m = 0; cmd_err_m = 1;
        nonce = $urandom;
        chk("coinc_no_req", newTarget, 0);
        check_status("coinc_status");
        bus_read(6'h22, d);
        chk("coinc_nonce", d, nonce_m);

        // Same-cycle read and write returns the old word
        old_w = tgt_m[3]; new_w = $urandom | 32'h1;
        wr_en = 1'b1; wr_addr = 6'h03; wr_data = new_w;
        rd_en = 1'b1; rd_addr = 6'h03;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        tgt_m[3] = new_w;
        chk("rdwr_old", rd_data, old_w);
        bus_read(6'h30, d);
        chk("unmapped_rd", d, 0);
        wr_word(6'h1B, $urandom, 0);
        check_shadow("unmapped_wr");
        bus_read(6'h03, d);
        chk("rdwr_new", d, new_w);

        // Asynchronous reset while newMsg is requested
        bus_write(6'h20, 32'h2);
        chk("pre_rst_req", newMsg, 1);
        chk("pre_rst_irq", irq, irq_m);
        n_rst = 1'b0;
        #2;
        chk("arst_req", {newMsg, newTarget}, 0);
        chk("arst_irq", irq, 0);
        chk("arst_rd_data", rd_data, 0);
        clear_model();
        check_shadow("arst");
        #2;
        n_rst = 1'b1;
        step();
        check_status("post_rst_status");
        bus_write(6'h20, 32'h1);
        chk("post_rst_idle", {newMsg, newTarget}, 2'b01);
        ack_target(0);
        chk("post_rst_drop", newTarget, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/miner_host_if.md
Name: miner_host_if

Overview:
- Host-facing register slave that sits on the other end of the mining controller's newTarget/newMsg/error interface.
- Host software writes target and header words through a simple synchronous word bus, then commits them with a command write.
- The block drives newTarget/newMsg as request levels, holds each until the controller acknowledges it via loadTarget/loadMsg, and reports result, nonce and error status back to the host.

Parameters:
- TGT_WORDS, 8, number of 32-bit target words (256-bit target).
- MSG_WORDS, 19, number of 32-bit header words excluding nonce (608 bits).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- wr_en  in  1  host write strobe, single cycle
- wr_addr  in  6  host write word address
- wr_data  in  32  host write data
- rd_en  in  1  host read strobe
- rd_addr  in  6  host read word address
- rd_data  out  32  registered read data
- irq  out  1  level interrupt to host
- newTarget  out  1  target-load request to controller
- newMsg  out  1  message-load request to controller
- target  out  32*TGT_WORDS  target shadow register, word 0 in LSBs
- msg  out  32*MSG_WORDS  header shadow register, word 0 in LSBs
- loadTarget  in  1  controller ack, target latched
- loadMsg  in  1  controller ack, message latched and mining started
- hash_found  in  1  one-cycle pulse, valid hash found
- error  in  1  controller level, nonce overflow idle
- nonce  in  32  controller's current nonce

Behaviour:
- Reset: all registers, rd_data, irq, newTarget, newMsg, target and msg are 0. The FSM enters H_IDLE.
- Address map:
  - 0x00-0x07: target words.
  - 0x08-0x1A: msg words.
  - 0x20: CMD, write-only. Bit0 commits target, bit1 commits msg.
  - 0x21: STATUS, read. Bits: [0] busy, [1] found, [2] error, [3] cmd_err, [4] wr_err. Any write to 0x21 clears found, cmd_err, wr_err and irq.
  - 0x22: NONCE, read. Returns nonce latched on hash_found.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Reads: rd_data updates on the clock edge after rd_en and holds until the next rd_en.
- FSM states:
  - H_IDLE, H_TGT_REQ, H_MSG_REQ: as defined by the transitions below.
  - H_MINING: busy=1.
- Transitions:
  - H_IDLE + CMD bit0 → H_TGT_REQ, newTarget=1.
  - H_IDLE + CMD bit1 only → H_MSG_REQ, newMsg=1.
  - H_TGT_REQ: hold newTarget until the cycle loadTarget=1.
    - Then go to H_MSG_REQ if bit1 was also committed, otherwise H_IDLE.
    - newTarget drops the cycle after loadTarget.
  - H_MSG_REQ: hold newMsg until loadMsg=1. Then go to H_MINING, clear the found bit, and drop newMsg the next cycle.
  - H_MINING + hash_found → H_IDLE; latch nonce, set found, set irq.
  - H_MINING + rising edge of error → H_IDLE; set irq.
- STATUS error bit mirrors the error input.
- CMD write with both bits set: target is always requested before msg, never both requests high at once.
- CMD write outside H_IDLE: ignored, cmd_err set.
- H_MINING + CMD write: ignored, cmd_err set. Aborting a run is not supported.
- Target/msg word write while in H_TGT_REQ or H_MSG_REQ: ignored, wr_err set. This keeps the shadow stable while the controller latches.
- Word writes in H_IDLE or H_MINING update the shadow immediately.
- hash_found and a CMD write in the same cycle: the result is recorded, and the CMD is rejected because state != H_IDLE at sampling.
- Simultaneous STATUS clear-write and a new found/error event: the set wins.
- wr_en and rd_en in the same cycle to the same address: the read returns the old value.
- Reset mid-request: requests drop immediately (asynchronous).

Decomposition:
- Package miner_host_pkg holds:
  - address constants ADDR_TGT_BASE, ADDR_MSG_BASE, ADDR_CMD, ADDR_STATUS, ADDR_NONCE;
  - STATUS bit indices;
  - the state enum host_state_t.
- One natural sub-module is host_regfile: word-addressed shadow storage for target/msg with a write-protect input. The FSM and status logic stay in the top module.

Test Plan:
- Write target words 0-7 = 0x1000_0000+i, CMD=0x1; ack loadTarget after 3 cycles → newTarget high for exactly 4 cycles, target[31:0]=0x1000_0000, busy=0 after.
- CMD=0x3 with loadTarget and then loadMsg acks → newTarget precedes newMsg, they never overlap, and STATUS busy=1 after loadMsg.
- In H_MINING, pulse hash_found with nonce=0xDEADBEEF → state H_IDLE, irq=1, STATUS=0x02, NONCE read=0xDEADBEEF one cycle after rd_en.
- In H_MINING, raise error → irq=1, STATUS error=1, busy=0; write 0x21 → irq=0.
- Write word 0x08 while in H_MSG_REQ → msg unchanged, wr_err=1; CMD write in H_MINING → cmd_err=1, no new request.
- Assert n_rst low while newMsg is high → newMsg, irq and rd_data are 0 immediately; after release the block is in H_IDLE.
